// File: rtl/invader_fleet_move.sv
// Formation-origin mover: right/down/left/down sweep paced by a tick divider, with pause, landing and restart.
// Optional macro INVADER_SPEEDUP_EN makes the tick period scale with the number of surviving invaders.
module invader_fleet_move #(
    parameter int X_START     = 0,
    parameter int Y_START     = 0,
    parameter int X_STEP      = 2,
    parameter int Y_STEP      = 16,
    parameter int X_SPAN      = 100,
    parameter int Y_LIMIT     = 600,
    parameter int TICK_PERIOD = 4_333_333,
    parameter int MIN_PERIOD  = 650_000,
    parameter int PER_ALIVE   = 65_000
) (
    input  logic       clk65MHz,
    input  logic       rst,
    input  logic       game_start,
    input  logic       pause,
    input  logic [7:0] alive_cnt,
    output logic [9:0] xpos,
    output logic [9:0] ypos,
    output logic       dir,
    output logic       step,
    output logic       landed
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RIGHT  = 3'd1,
        S_DOWN_R = 3'd2,
        S_LEFT   = 3'd3,
        S_DOWN_L = 3'd4,
        S_LANDED = 3'd5
    } state_t;

    localparam logic [9:0]  L_X_START = 10'(X_START);
    localparam logic [9:0]  L_Y_START = 10'(Y_START);
    localparam logic [9:0]  L_X_STEP  = 10'(X_STEP);
    localparam logic [9:0]  L_Y_STEP  = 10'(Y_STEP);
    localparam logic [9:0]  L_X_SPAN  = 10'(X_SPAN);
    localparam logic [9:0]  L_Y_LIMIT = 10'(Y_LIMIT);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_cnt;
    logic [31:0] w_period;
    logic [9:0]  r_span;
    logic [9:0]  r_x;
    logic [9:0]  r_y;
    logic        r_dir;
    logic        r_step;
    logic        r_landed;

    logic [9:0]  w_span_nxt;
    logic [9:0]  w_x_nxt;
    logic [9:0]  w_y_nxt;
    logic        w_dir_nxt;
    logic        w_step_nxt;
    logic        w_landed_nxt;

    logic        w_moving;
    logic        w_start;
    logic        w_tick;
    logic        w_move;
    logic [9:0]  w_span_add;
    logic [9:0]  w_y_add;
    logic        w_hit_floor;

    assign w_moving    = (r_state == S_RIGHT) || (r_state == S_DOWN_R) ||
                         (r_state == S_LEFT)  || (r_state == S_DOWN_L);
    assign w_start     = game_start && ((r_state == S_IDLE) || (r_state == S_LANDED));
    assign w_tick      = w_moving && !pause && (r_cnt == (w_period - 32'd1));
    // Ticks keep running with an empty fleet; only the move itself is dropped.
    assign w_move      = w_tick && (alive_cnt != 8'd0);
    assign w_span_add  = r_span + L_X_STEP;
    assign w_y_add     = r_y + L_Y_STEP;
    assign w_hit_floor = (w_y_add >= L_Y_LIMIT);

`ifdef INVADER_SPEEDUP_EN
    logic [31:0] r_period;
    logic [31:0] w_period_new;

    assign w_period_new = 32'(MIN_PERIOD) + (32'(alive_cnt) * 32'(PER_ALIVE));
    assign w_period     = r_period;

    // Period is latched only at wrap or start so a mid-period alive_cnt change waits a period.
    always_ff @(posedge clk65MHz or posedge rst) begin
        if (rst) begin
            r_period <= 32'(MIN_PERIOD);
        end else if (w_start || w_tick) begin
            r_period <= w_period_new;
        end else begin
            r_period <= r_period;
        end
    end
`else
    assign w_period = 32'(TICK_PERIOD);
`endif

    // Tick divider: counts 0..P-1 while sweeping, frozen by pause.
    always_ff @(posedge clk65MHz or posedge rst) begin
        if (rst) begin
            r_cnt <= 32'd0;
        end else if (w_start) begin
            r_cnt <= 32'd0;
        end else if (w_moving && !pause) begin
            r_cnt <= w_tick ? 32'd0 : (r_cnt + 32'd1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // State register.
    always_ff @(posedge clk65MHz or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (game_start) w_state_nxt = S_RIGHT;
                      else            w_state_nxt = S_IDLE;
            S_RIGHT:  if (w_move && (w_span_add >= L_X_SPAN)) w_state_nxt = S_DOWN_R;
                      else                                     w_state_nxt = S_RIGHT;
            S_DOWN_R: if (w_move) w_state_nxt = w_hit_floor ? S_LANDED : S_LEFT;
                      else        w_state_nxt = S_DOWN_R;
            S_LEFT:   if (w_move && (w_span_add >= L_X_SPAN)) w_state_nxt = S_DOWN_L;
                      else                                     w_state_nxt = S_LEFT;
            S_DOWN_L: if (w_move) w_state_nxt = w_hit_floor ? S_LANDED : S_RIGHT;
                      else        w_state_nxt = S_DOWN_L;
            S_LANDED: if (game_start) w_state_nxt = S_RIGHT;
                      else            w_state_nxt = S_LANDED;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Next output values; step is raised only alongside an applied move.
    always_comb begin
        w_span_nxt   = r_span;
        w_x_nxt      = r_x;
        w_y_nxt      = r_y;
        w_dir_nxt    = r_dir;
        w_step_nxt   = 1'b0;
        w_landed_nxt = r_landed;
        case (r_state)
            S_IDLE: begin
                if (game_start) w_span_nxt = 10'd0;
                else            w_span_nxt = r_span;
            end
            S_RIGHT, S_LEFT: begin
                if (w_move) begin
                    w_x_nxt    = (r_state == S_RIGHT) ? (r_x + L_X_STEP) : (r_x - L_X_STEP);
                    w_span_nxt = w_span_add;
                    w_step_nxt = 1'b1;
                end else begin
                    w_step_nxt = 1'b0;
                end
            end
            S_DOWN_R, S_DOWN_L: begin
                if (w_move) begin
                    w_y_nxt      = w_y_add;
                    w_span_nxt   = 10'd0;
                    w_dir_nxt    = (r_state == S_DOWN_R);
                    w_step_nxt   = 1'b1;
                    w_landed_nxt = w_hit_floor;
                end else begin
                    w_step_nxt = 1'b0;
                end
            end
            S_LANDED: begin
                if (game_start) begin
                    w_x_nxt      = L_X_START;
                    w_y_nxt      = L_Y_START;
                    w_dir_nxt    = 1'b0;
                    w_span_nxt   = 10'd0;
                    w_landed_nxt = 1'b0;
                end else begin
                    w_step_nxt = 1'b0;
                end
            end
            default: begin
                w_step_nxt = 1'b0;
            end
        endcase
    end

    // Output and span registers.
    always_ff @(posedge clk65MHz or posedge rst) begin
        if (rst) begin
            r_span   <= 10'd0;
            r_x      <= L_X_START;
            r_y      <= L_Y_START;
            r_dir    <= 1'b0;
            r_step   <= 1'b0;
            r_landed <= 1'b0;
        end else begin
            r_span   <= w_span_nxt;
            r_x      <= w_x_nxt;
            r_y      <= w_y_nxt;
            r_dir    <= w_dir_nxt;
            r_step   <= w_step_nxt;
            r_landed <= w_landed_nxt;
        end
    end

    assign xpos   = r_x;
    assign ypos   = r_y;
    assign dir    = r_dir;
    assign step   = r_step;
    assign landed = r_landed;

endmodule

// File: tb/tb_invader_fleet_move.sv
// Scoreboard bench for invader_fleet_move: expected moves are queued with their arrival cycle and
// popped when a step pulse is seen.
module tb_invader_fleet_move;

`ifdef INVADER_SPEEDUP_EN
    localparam int P = 7;
`else
    localparam int P = 4;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       game_start = 1'b0;
    logic       pause = 1'b0;
    logic [7:0] alive_cnt = 8'd5;
    logic [9:0] xpos;
    logic [9:0] ypos;
    logic       dir;
    logic       step;
    logic       landed;

    invader_fleet_move #(
        .X_START(10), .Y_START(0), .X_STEP(2), .Y_STEP(16), .X_SPAN(6), .Y_LIMIT(48),
        .TICK_PERIOD(4), .MIN_PERIOD(2), .PER_ALIVE(1)
    ) dut (
        .clk65MHz(clk), .rst(rst), .game_start(game_start), .pause(pause),
        .alive_cnt(alive_cnt), .xpos(xpos), .ypos(ypos), .dir(dir), .step(step), .landed(landed)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         c;
        logic       cc;
        logic [9:0] x;
        logic [9:0] y;
        logic       d;
        logic       cd;
        logic       l;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   last_step = 0;

    task automatic push_move(input int c, input logic cc, input int x, input int y,
                             input logic d, input logic cd, input logic l);
        exp_t e;
        e.c = c; e.cc = cc; e.x = 10'(x); e.y = 10'(y); e.d = d; e.cd = cd; e.l = l;
        sb.push_back(e);
    endtask

    task automatic wait_step(input int max, output int found);
        found = -1;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (step === 1'b1) begin
                found = cyc;
                break;
            end
        end
    endtask

    task automatic pulse_start(output int acc);
        @(negedge clk);
        game_start = 1'b1;
        @(negedge clk);
        game_start = 1'b0;
        acc = cyc;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if ({xpos, ypos, dir, step, landed} !== {10'd10, 10'd0, 1'b0, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL reset_idle cycle %0d: x=%0d y=%0d dir=%b step=%b landed=%b, want x=10 y=0 dir=0 step=0 landed=0",
                         i, xpos, ypos, dir, step, landed);
            end
        end
    endtask

    task automatic test_sweep();
        int a, f;
        exp_t e;
        pulse_start(a);
        push_move(a + 1*P, 1'b1, 12,  0, 1'b0, 1'b1, 1'b0);
        push_move(a + 2*P, 1'b1, 14,  0, 1'b0, 1'b1, 1'b0);
        push_move(a + 3*P, 1'b1, 16,  0, 1'b0, 1'b1, 1'b0);
        push_move(a + 4*P, 1'b1, 16, 16, 1'b1, 1'b1, 1'b0);
        push_move(a + 5*P, 1'b1, 14, 16, 1'b1, 1'b1, 1'b0);
        push_move(a + 6*P, 1'b1, 12, 16, 1'b1, 1'b1, 1'b0);
        push_move(a + 7*P, 1'b1, 10, 16, 1'b1, 1'b1, 1'b0);
        push_move(a + 8*P, 1'b1, 10, 32, 1'b0, 1'b1, 1'b0);
        repeat (8) begin
            wait_step(3 * P, f);
            e = sb.pop_front();
            checks++;
            if ((e.cc && f !== e.c) || f < 0 || xpos !== e.x || ypos !== e.y ||
                (e.cd && dir !== e.d) || landed !== e.l) begin
                errors++;
                $display("FAIL sweep: cyc=%0d x=%0d y=%0d dir=%b landed=%b, want cyc=%0d x=%0d y=%0d dir=%b landed=%b",
                         f, xpos, ypos, dir, landed, e.c, e.x, e.y, e.d, e.l);
            end
            last_step = f;
        end
    endtask

    task automatic test_pause();
        int f, seen;
        exp_t e;
        repeat (2) @(negedge clk);
        pause = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (step === 1'b1) seen++;
        end
        pause = 1'b0;
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL pause_no_step: %0d steps while paused, want 0", seen);
        end
        push_move(cyc + P - 2, 1'b1, 12, 32, 1'b0, 1'b1, 1'b0);
        wait_step(3 * P, f);
        e = sb.pop_front();
        checks++;
        if (f !== e.c || xpos !== e.x || ypos !== e.y || dir !== e.d || landed !== e.l) begin
            errors++;
            $display("FAIL pause_resume: cyc=%0d x=%0d y=%0d, want cyc=%0d x=%0d y=%0d",
                     f, xpos, ypos, e.c, e.x, e.y);
        end
        last_step = f;
    endtask

    task automatic test_landing_restart();
        int f, a;
        exp_t e;
        push_move(last_step + 1*P, 1'b1, 14, 32, 1'b0, 1'b1, 1'b0);
        push_move(last_step + 2*P, 1'b1, 16, 32, 1'b0, 1'b1, 1'b0);
        push_move(last_step + 3*P, 1'b1, 16, 48, 1'b0, 1'b0, 1'b1);
        repeat (3) begin
            wait_step(3 * P, f);
            e = sb.pop_front();
            checks++;
            if (f !== e.c || xpos !== e.x || ypos !== e.y || (e.cd && dir !== e.d) || landed !== e.l) begin
                errors++;
                $display("FAIL landing: cyc=%0d x=%0d y=%0d dir=%b landed=%b, want cyc=%0d x=%0d y=%0d landed=%b",
                         f, xpos, ypos, dir, landed, e.c, e.x, e.y, e.l);
            end
        end
        wait_step(40, f);
        checks++;
        if (f !== -1) begin
            errors++;
            $display("FAIL landed_quiet: step at cyc=%0d, want none for 40 cycles", f);
        end
        checks++;
        if ({xpos, ypos, landed} !== {10'd16, 10'd48, 1'b1}) begin
            errors++;
            $display("FAIL landed_hold: x=%0d y=%0d landed=%b, want x=16 y=48 landed=1", xpos, ypos, landed);
        end
        pulse_start(a);
        checks++;
        if ({xpos, ypos, dir, landed, step} !== {10'd10, 10'd0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL restart_load: x=%0d y=%0d dir=%b landed=%b step=%b, want x=10 y=0 dir=0 landed=0 step=0",
                     xpos, ypos, dir, landed, step);
        end
        push_move(a + P, 1'b1, 12, 0, 1'b0, 1'b1, 1'b0);
        wait_step(3 * P, f);
        e = sb.pop_front();
        checks++;
        if (f !== e.c || xpos !== e.x || ypos !== e.y || landed !== e.l) begin
            errors++;
            $display("FAIL restart_step: cyc=%0d x=%0d y=%0d, want cyc=%0d x=%0d y=%0d", f, xpos, ypos, e.c, e.x, e.y);
        end
        last_step = f;
    endtask

    task automatic test_empty_fleet();
        int f, seen, nxt;
        exp_t e;
        alive_cnt = 8'd0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (step === 1'b1) seen++;
        end
        checks++;
        if (seen != 0 || xpos !== 10'd12 || ypos !== 10'd0) begin
            errors++;
            $display("FAIL empty_fleet: steps=%0d x=%0d y=%0d, want steps=0 x=12 y=0", seen, xpos, ypos);
        end
        alive_cnt = 8'd5;
        nxt = last_step;
        while (nxt <= cyc) nxt += P;
`ifdef INVADER_SPEEDUP_EN
        push_move(nxt, 1'b0, 14, 0, 1'b0, 1'b1, 1'b0);
`else
        push_move(nxt, 1'b1, 14, 0, 1'b0, 1'b1, 1'b0);
`endif
        wait_step(4 * P, f);
        e = sb.pop_front();
        checks++;
        if ((e.cc && f !== e.c) || f < 0 || xpos !== e.x || ypos !== e.y) begin
            errors++;
            $display("FAIL fleet_resume: cyc=%0d x=%0d y=%0d, want cyc=%0d x=%0d y=%0d", f, xpos, ypos, e.c, e.x, e.y);
        end
    endtask

    task automatic test_async_reset();
        int f;
        @(negedge clk);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({xpos, ypos, dir, step, landed} !== {10'd10, 10'd0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: x=%0d y=%0d dir=%b step=%b landed=%b, want x=10 y=0 dir=0 step=0 landed=0",
                     xpos, ypos, dir, step, landed);
        end
        @(negedge clk);
        rst = 1'b0;
        wait_step(3 * P, f);
        checks++;
        if (f !== -1 || xpos !== 10'd10) begin
            errors++;
            $display("FAIL reset_idle_after: step cyc=%0d x=%0d, want no step x=10", f, xpos);
        end
    endtask

`ifdef INVADER_SPEEDUP_EN
    task automatic test_speedup();
        int a, f;
        exp_t e;
        alive_cnt = 8'd3;
        pulse_start(a);
        push_move(a + 5,  1'b1, 12,  0, 1'b0, 1'b1, 1'b0);
        push_move(a + 10, 1'b1, 14,  0, 1'b0, 1'b1, 1'b0);
        push_move(a + 15, 1'b1, 16,  0, 1'b0, 1'b1, 1'b0);
        push_move(a + 18, 1'b1, 16, 16, 1'b1, 1'b1, 1'b0);
        push_move(a + 21, 1'b1, 14, 16, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            wait_step(12, f);
            e = sb.pop_front();
            checks++;
            if (f !== e.c || xpos !== e.x || ypos !== e.y || dir !== e.d) begin
                errors++;
                $display("FAIL speedup: cyc=%0d x=%0d y=%0d dir=%b, want cyc=%0d x=%0d y=%0d dir=%b",
                         f, xpos, ypos, dir, e.c, e.x, e.y, e.d);
            end
            if (k == 1) begin
                repeat (2) @(negedge clk);
                alive_cnt = 8'd1;
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_sweep();
        test_pause();
        test_landing_restart();
        test_empty_fleet();
        test_async_reset();
`ifdef INVADER_SPEEDUP_EN
        test_speedup();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/invader_fleet_move.md
# invader_fleet_move

Parametrised movement controller for the invader formation; successor to the fixed-offset single-invader mover. It generates a stepped right/down/left/down sweep, paced by an internal tick divider. It adds pause, a landing floor with a sticky `landed` flag, restart from landing, a per-move strobe and an optional speed-up that scales with surviving invaders. One instance drives the formation origin; the invader renderers add per-invader offsets.

## Interface
- `X_START`, 0: x origin loaded at reset and restart
- `Y_START`, 0: y origin loaded at reset and restart
- `X_STEP`, 2: horizontal step per tick (pixels)
- `Y_STEP`, 16: vertical step per descent (pixels)
- `X_SPAN`, 100: horizontal travel per sweep before descending
- `Y_LIMIT`, 600: landing threshold on `ypos`
- `TICK_PERIOD`, 4_333_333: clocks per tick, fixed mode (65 MHz / 15)
- `MIN_PERIOD`, 650_000: speed-up mode base period
- `PER_ALIVE`, 65_000: speed-up mode extra clocks per alive invader
- `clk65MHz` in 1: system clock
- `rst` in 1: reset, asynchronous, active-high
- `game_start` in 1: start/restart request, level-sampled
- `pause` in 1: freezes tick counter and movement while high
- `alive_cnt` in 8: number of invaders still alive
- `xpos` out 10: formation x origin
- `ypos` out 10: formation y origin
- `dir` out 1: 0 = moving right, 1 = moving left
- `step` out 1: one-cycle pulse on every applied move
- `landed` out 1: sticky; high once the fleet has reached `Y_LIMIT`

## Operation
- **Reset values:** `xpos`=X_START, `ypos`=Y_START, `dir`=0, `step`=0, `landed`=0, state IDLE, tick counter 0, span counter 0.
- **States:** IDLE, RIGHT, DOWN_R, LEFT, DOWN_L, LANDED.
- **IDLE:** positions held. If `game_start`=1, go to RIGHT and clear the tick counter.
- **RIGHT:** on each tick, `xpos` += X_STEP and span += X_STEP. When span >= X_SPAN (after the update), go to DOWN_R.
- **DOWN_R:** waits for the next tick. On that tick, `ypos` += Y_STEP, span is cleared, `dir`=1, and the block goes to LEFT. Descent is never skipped; this state does not time out.
- **LEFT:** mirror of RIGHT, with `xpos` -= X_STEP.
- **DOWN_L:** mirror of DOWN_R; sets `dir`=0 and goes to RIGHT.
- **Landing:** if a descent makes `ypos` >= Y_LIMIT, go to LANDED and set `landed`=1 on the same edge. In LANDED, outputs are held and no `step` pulses occur.
- **Restart:** `game_start` in LANDED reloads start positions, clears `landed`, `dir` and span, and goes to RIGHT. `game_start` in any other non-IDLE state is ignored.
- **Tick:** the counter counts 0..P-1. Reaching P-1 produces a tick and wraps to 0.
- **Pause:** `pause`=1 holds the counter and suppresses ticks. The counter resumes from its held value afterwards.
- **Empty fleet:** `alive_cnt`=0 suppresses moves. The counter still runs; positions and state are held.
- **Arithmetic:** 10-bit unsigned, wrapping modulo 1024, with no clamping. Integrator guarantees X_START + X_SPAN + X_STEP < 1024, X_START >= X_SPAN + X_STEP relative to the left sweep, and Y_LIMIT + Y_STEP < 1024. The span counter is 10 bits.

## Timing
- All outputs are registered.
- `xpos`, `ypos`, `dir`, `landed` and `step` update on the same edge. `step`=1 exactly in the cycle in which new values first appear.
- The first move occurs P cycles after the edge that accepts `game_start`.
- Consecutive moves are exactly P cycles apart when unpaused.
- State transitions out of RIGHT/LEFT occur on the edge that applies the final step; the next tick applies the descent.
- `rst` asserted at any time, including mid-period or in LANDED, forces reset values immediately, without waiting for a clock edge. Deassertion takes effect at the next edge.

## Configuration
- `INVADER_SPEEDUP_EN`
  - **Defined:** P = MIN_PERIOD + `alive_cnt` × PER_ALIVE, sampled when the counter wraps to 0 (and on IDLE/LANDED→RIGHT). Changes to `alive_cnt` mid-period take effect at the next period.
  - **Undefined:** P = TICK_PERIOD; `alive_cnt` affects only the empty-fleet suppression.

## Test plan
Bench parameters: TICK_PERIOD=4, X_START=10, Y_START=0, X_STEP=2, X_SPAN=6, Y_STEP=16, Y_LIMIT=48, `alive_cnt`=5.

1. **Reset and idle:** reset, then hold `game_start`=0 for 20 cycles -> `xpos`=10, `ypos`=0, `dir`=0, `step`=0, `landed`=0 throughout.
2. **Full sweep:** pulse `game_start` -> `step` every 4 cycles. `xpos` goes 12, 14, 16; then `ypos`=16 with `dir`=1; then `xpos` 14, 12, 10; then `ypos`=32 with `dir`=0.
3. **Pause:** assert `pause` for 10 cycles, 2 cycles after a step -> no step during pause; the next step arrives 2 cycles after `pause` falls.
4. **Landing and restart:** continue the sweep -> `ypos`=48 with `landed`=1; no further steps for 40 cycles. Pulse `game_start` -> `xpos`=10, `ypos`=0, `landed`=0, and `step` resumes 4 cycles later.
5. **Async reset and empty fleet:** assert `rst` mid-period between clock edges -> `xpos`=10, `ypos`=0 immediately. Separately, set `alive_cnt`=0 while running -> no steps and positions frozen; restoring `alive_cnt`=5 resumes steps.
6. **Speed-up mode:** with `INVADER_SPEEDUP_EN`, MIN_PERIOD=2, PER_ALIVE=1, `alive_cnt`=3 -> steps every 5 cycles. Change `alive_cnt` to 1 mid-period -> that period stays 5; following periods are 3.
